huff_bit_window: RTL and testbench
==================================

Name: huff_bit_window

Overview:
- Upstream feeder for the Huffman decoder.
- Accepts the compressed stream as 8-bit bytes over a valid/ready handshake and holds them in a bit buffer.
- Presents a 10-bit MSB-first sliding window, the maximum code length, to the decoder.
- Advances the window by the decoded symbol length the decoder reports; at end of stream, drains the remaining bits with zero padding.

Parameters:
- IN_W, 8, input byte width
- WIN_W, 10, window width (max code length)
- BUF_W, 24, bit buffer width; must be >= WIN_W + IN_W
- CNT_W, 5, width of bit counter; must satisfy 2^CNT_W > BUF_W
- LEN_W, 4, width of consume length

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse: begin a new stream (IDLE/DONE only)
- in_data  in  IN_W  stream byte; bit 7 is the earliest bit
- in_valid  in  1  in_data valid
- in_last  in  1  qualifies the final byte of the stream
- in_ready  out  1  block accepts a byte this cycle
- win_data  out  WIN_W  buf[BUF_W-1 -: WIN_W]; bits beyond cnt read 0
- win_valid  out  1  window usable by decoder
- consume  in  1  decoder consumed a symbol
- consume_len  in  LEN_W  bits consumed, legal 1..WIN_W
- bits_avail  out  CNT_W  current cnt
- done  out  1  stream fully consumed; level
- err  out  1  sticky: illegal consume

Behaviour:
- Storage: buf[BUF_W-1:0] is left-aligned (oldest bit at MSB); cnt holds valid bits 0..BUF_W; buf bits below the valid region are always 0.
- Reset (rst=1, async): buf=0, cnt=0, state=IDLE, done=0, err=0. Outputs: in_ready=0, win_valid=0, win_data=0.
- States:
  - IDLE: wait for start.
  - FILL: cnt < WIN_W and in_last not yet seen.
  - RUN: cnt >= WIN_W.
  - DRAIN: last byte accepted.
  - DONE: stream fully consumed.
- Transitions:
  - IDLE --start--> FILL. start also clears buf, cnt and err.
  - FILL <-> RUN: re-evaluated each cycle on next cnt (RUN when cnt_next >= WIN_W, else FILL).
  - FILL/RUN --accepted byte with in_last--> DRAIN.
  - DRAIN --cnt_next==0--> DONE.
  - DONE --start--> FILL; done drops in the same cycle.
  - start in FILL/RUN/DRAIN is ignored.
- in_ready = (state in FILL, RUN) && (cnt <= BUF_W-IN_W). Combinational from registered state; does not depend on consume.
- Byte accept = in_valid && in_ready.
- win_valid:
  - 1 in RUN.
  - 1 in DRAIN while cnt > 0.
  - 0 in all other states.
- Consume rules:
  - Acts only when consume && win_valid && 1 <= consume_len <= WIN_W.
  - Effect: buf shifts left by consume_len with zero fill; cnt -= consume_len.
  - consume_len > cnt (possible in DRAIN): cnt clamps to 0, buf clears, err is set.
  - consume_len == 0, consume_len > WIN_W, or consume while win_valid=0: no shift, err is set.
- Simultaneous consume and accept in one cycle: shift first, then write the byte at bit position BUF_W-1-(cnt-len) downward; cnt_next = cnt - len + IN_W. There is no lost or duplicated bit.
- Latency:
  - Accepted byte is visible in win_data the next cycle.
  - After a consume, the next window is valid the next cycle (one symbol per cycle sustained when cnt stays >= WIN_W).
- done = (state == DONE).
- win_data in DRAIN is zero-padded; the decoder relies on the padding never being consumed beyond cnt.
- Width rule: all cnt arithmetic is CNT_W unsigned; subtraction uses the clamp rule above, never wrap-around.
- rst mid-stream: immediate abort to the reset state; no partial byte is retained.

Decomposition:
- Shared package huff_pkg holds:
  - state enum (IDLE, FILL, RUN, DRAIN, DONE)
  - HUFF_MAX_CODE_LEN = 10, shared with the decoder
  - HUFF_BYTE_W = 8
- One natural sub-module, huff_bit_shifter: combinational shift-by-len plus insert-at-offset datapath. The FSM and counters stay in huff_bit_window.

Test Plan:
- Reset then start; feed 0xA5, 0x3C -> after the 2nd accept: cnt=16, win_valid=1, win_data=10'b1010010100.
- From cnt=16, consume_len=4 with no input -> next cycle: cnt=12, win_data=10'b0101001111.
- Hold cnt=16 and drive an accept of 0xFF together with consume_len=6 -> cnt=18, window continuous across the byte boundary, no bit lost.
- Push bytes without consuming -> in_ready drops at cnt=24 (3 bytes); with in_valid held, a 4th byte is accepted only after a consume frees >= 8 bits.
- Final byte 0x80 with in_last (cnt=8 after it) -> DRAIN, win_valid=1, win_data=10'b1000000000; consume 1, then 7 -> cnt=0, done=1 next cycle, err=0.
- Error and reset cases:
  - In DRAIN with cnt=3, consume_len=5 -> cnt=0, err=1 sticky.
  - Assert rst mid-RUN -> all outputs return to reset values asynchronously.
  - start after DONE -> err clears, state FILL.

Source files
------------

// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman front end: state encoding and code-length constants.
package huff_pkg;

    localparam int unsigned HUFF_MAX_CODE_LEN = 10;
    localparam int unsigned HUFF_BYTE_W       = 8;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StRun,
        StDrain,
        StDone
    } huff_state_e;

endpackage

// File: rtl/huff_bit_shifter.sv
// Bit-buffer datapath: shift out consumed bits, then drop a new byte in right after the survivors.
module huff_bit_shifter
    import huff_pkg::*;
#(
    parameter int unsigned IN_W  = HUFF_BYTE_W,
    parameter int unsigned BUF_W = 24,
    parameter int unsigned CNT_W = 5
) (
    input  logic [BUF_W-1:0] buf_cur,
    input  logic [CNT_W-1:0] shift_amt,
    input  logic [CNT_W-1:0] ins_pos,
    input  logic             ins_en,
    input  logic [IN_W-1:0]  ins_data,
    output logic [BUF_W-1:0] buf_next
);

    logic [BUF_W-1:0] ins_aligned;

    // Bits below the valid region are always zero, so OR-ing the byte in is enough.
    always_comb begin
        ins_aligned = '0;
        if (ins_en) begin
            ins_aligned = {ins_data, {(BUF_W - IN_W){1'b0}}} >> ins_pos;
        end
        buf_next = (buf_cur << shift_amt) | ins_aligned;
    end

endmodule

// File: rtl/huff_bit_window.sv
// Byte-to-bit feeder for the Huffman decoder: buffers the stream and presents a sliding
// MSB-first window that advances by each decoded symbol length.
module huff_bit_window
    import huff_pkg::*;
#(
    parameter int unsigned IN_W  = HUFF_BYTE_W,
    parameter int unsigned WIN_W = HUFF_MAX_CODE_LEN,
    parameter int unsigned BUF_W = 24,
    parameter int unsigned CNT_W = 5,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIN_W-1:0] win_data,
    output logic             win_valid,
    input  logic             consume,
    input  logic [LEN_W-1:0] consume_len,
    output logic [CNT_W-1:0] bits_avail,
    output logic             done,
    output logic             err
);

    huff_state_e      state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d, buf_shifted;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [CNT_W-1:0] len_ext, shift_amt, cnt_rem, cnt_next;
    logic             accept, len_legal, over, do_consume, consume_err;

    assign accept      = in_valid && in_ready;
    assign len_ext     = CNT_W'(consume_len);
    assign len_legal   = (len_ext != '0) && (len_ext <= CNT_W'(WIN_W));
    assign over        = len_ext > cnt_q;
    assign do_consume  = consume && win_valid && len_legal;
    assign consume_err = consume && (!win_valid || !len_legal || over);

    // Over-long consumes shift out exactly cnt bits, which empties the buffer without wrap.
    assign shift_amt = do_consume ? (over ? cnt_q : len_ext) : '0;
    assign cnt_rem   = cnt_q - shift_amt;
    assign cnt_next  = cnt_rem + (accept ? CNT_W'(IN_W) : '0);

    huff_bit_shifter #(
        .IN_W  (IN_W),
        .BUF_W (BUF_W),
        .CNT_W (CNT_W)
    ) u_shifter (
        .buf_cur   (buf_q),
        .shift_amt (shift_amt),
        .ins_pos   (cnt_rem),
        .ins_en    (accept),
        .ins_data  (in_data),
        .buf_next  (buf_shifted)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            buf_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        err_d   = err_q | consume_err;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StFill;
                    buf_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StFill, StRun: begin
                buf_d = buf_shifted;
                cnt_d = cnt_next;
                if (accept && in_last) begin
                    state_d = StDrain;
                end else if (cnt_next >= CNT_W'(WIN_W)) begin
                    state_d = StRun;
                end else begin
                    state_d = StFill;
                end
            end
            StDrain: begin
                buf_d = buf_shifted;
                cnt_d = cnt_next;
                if (cnt_next == '0) begin
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        in_ready   = ((state_q == StFill) || (state_q == StRun)) &&
                     (cnt_q <= CNT_W'(BUF_W - IN_W));
        win_valid  = (state_q == StRun) || ((state_q == StDrain) && (cnt_q != '0));
        win_data   = buf_q[BUF_W-1 -: WIN_W];
        bits_avail = cnt_q;
        done       = (state_q == StDone);
        err        = err_q;
    end

endmodule

// File: tb/tb_huff_bit_window.sv
// Directed plus random stimulus for huff_bit_window against a bit-queue reference model.
module tb_huff_bit_window;

    localparam int S_IDLE  = 0;
    localparam int S_FILL  = 1;
    localparam int S_RUN   = 2;
    localparam int S_DRAIN = 3;
    localparam int S_DONE  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic [9:0] win_data;
    logic       win_valid;
    logic       consume = 1'b0;
    logic [3:0] consume_len = '0;
    logic [4:0] bits_avail;
    logic       done;
    logic       err;

    int total = 0;
    int bad   = 0;

    bit mq[$];
    int mst = S_IDLE;
    bit merr = 1'b0;

    huff_bit_window dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .win_data    (win_data),
        .win_valid   (win_valid),
        .consume     (consume),
        .consume_len (consume_len),
        .bits_avail  (bits_avail),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] exp_win();
        logic [9:0] w;
        w = '0;
        for (int i = 0; i < 10; i++) begin
            if (i < mq.size()) w[9-i] = mq[i];
        end
        return w;
    endfunction

    function automatic bit exp_ready();
        return ((mst == S_FILL) || (mst == S_RUN)) && (mq.size() <= 16);
    endfunction

    function automatic bit exp_wv();
        return (mst == S_RUN) || ((mst == S_DRAIN) && (mq.size() > 0));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("bits_avail", 32'(bits_avail), 32'(mq.size()));
        chk("win_valid", 32'(win_valid), 32'(exp_wv()));
        chk("win_data", 32'(win_data), 32'(exp_win()));
        chk("in_ready", 32'(in_ready), 32'(exp_ready()));
        chk("done", 32'(done), 32'(mst == S_DONE));
        chk("err", 32'(err), 32'(merr));
    endtask

    task automatic model_reset();
        mq.delete();
        mst  = S_IDLE;
        merr = 1'b0;
    endtask

    task automatic step(input bit st, input bit v, input logic [7:0] d, input bit last,
                        input bit c, input logic [3:0] len);
        bit acc;
        bit wv;
        acc = v && exp_ready();
        wv  = exp_wv();
        start = st; in_valid = v; in_data = d; in_last = last;
        consume = c; consume_len = len;
        @(posedge clk);
        #1;
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0; consume = 1'b0;
        if (st && ((mst == S_IDLE) || (mst == S_DONE))) begin
            mq.delete();
            merr = 1'b0;
            mst  = S_FILL;
        end else begin
            if (c) begin
                if (!wv || (len == 0) || (len > 10)) begin
                    merr = 1'b1;
                end else if (int'(len) > mq.size()) begin
                    mq.delete();
                    merr = 1'b1;
                end else begin
                    repeat (int'(len)) void'(mq.pop_front());
                end
            end
            if (acc) begin
                for (int i = 7; i >= 0; i--) mq.push_back(d[i]);
            end
            if ((mst == S_FILL) || (mst == S_RUN)) begin
                if (acc && last) mst = S_DRAIN;
                else mst = (mq.size() >= 10) ? S_RUN : S_FILL;
            end else if ((mst == S_DRAIN) && (mq.size() == 0)) begin
                mst = S_DONE;
            end
        end
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Power-on reset and the first stream
        do_reset();
        step(1, 0, 8'h00, 0, 0, 0);
        step(0, 1, 8'hA5, 0, 0, 0);
        step(0, 1, 8'h3C, 0, 0, 0);
        chk("tp_cnt16", 32'(bits_avail), 32'd16);
        chk("tp_win_a53c", 32'(win_data), 32'b1010010100);
        step(0, 0, 8'h00, 0, 1, 4);
        chk("tp_cnt12", 32'(bits_avail), 32'd12);
        chk("tp_win_after4", 32'(win_data), 32'b0101001111);

        // Back to 16, then simultaneous accept and consume across the byte boundary
        step(0, 1, 8'h00, 0, 1, 4);
        step(0, 1, 8'hFF, 0, 1, 6);
        chk("tp_cnt18", 32'(bits_avail), 32'd18);

        // Fill to the top and hold in_valid until a consume frees a byte slot
        step(0, 0, 8'h00, 0, 1, 2);
        step(0, 1, 8'h96, 0, 0, 0);
        chk("tp_full_ready", 32'(in_ready), 32'd0);
        step(0, 1, 8'h11, 0, 0, 0);
        step(0, 1, 8'h11, 0, 1, 8);
        step(0, 1, 8'h11, 0, 0, 0);
        chk("tp_refill24", 32'(bits_avail), 32'd24);

        // Random traffic, consuming only legal lengths while a window is offered
        for (int n = 0; n < 400; n++) begin
            bit rv, rc;
            logic [7:0] rd;
            logic [3:0] rl;
            rv = 1'($urandom_range(0, 1));
            rd = 8'($urandom);
            rc = exp_wv() && ($urandom_range(0, 2) != 0);
            rl = 4'($urandom_range(1, 10));
            step(0, rv, rd, 0, rc, rl);
        end

        // Single final byte, drained with zero padding
        do_reset();
        step(1, 0, 8'h00, 0, 0, 0);
        step(0, 1, 8'h80, 1, 0, 0);
        chk("tp_drain_win", 32'(win_data), 32'b1000000000);
        chk("tp_drain_wv", 32'(win_valid), 32'd1);
        step(0, 0, 8'h00, 0, 1, 1);
        step(0, 0, 8'h00, 0, 1, 7);
        chk("tp_done", 32'(done), 32'd1);
        chk("tp_done_err", 32'(err), 32'd0);

        // Restart from DONE; over-consume in DRAIN sets a sticky error
        step(1, 0, 8'h00, 0, 0, 0);
        step(0, 1, 8'hE0, 1, 0, 0);
        step(0, 0, 8'h00, 0, 1, 5);
        step(0, 0, 8'h00, 0, 1, 5);
        chk("tp_clamp_cnt", 32'(bits_avail), 32'd0);
        chk("tp_clamp_err", 32'(err), 32'd1);
        step(0, 0, 8'h00, 0, 0, 0);
        step(1, 0, 8'h00, 0, 0, 0);
        chk("tp_restart_err", 32'(err), 32'd0);
        chk("tp_restart_ready", 32'(in_ready), 32'd1);

        // Illegal lengths in RUN: no shift, error flagged
        step(0, 1, 8'h5A, 0, 0, 0);
        step(0, 1, 8'hC3, 0, 0, 0);
        step(0, 0, 8'h00, 0, 1, 0);
        chk("tp_len0_cnt", 32'(bits_avail), 32'd16);
        step(0, 0, 8'h00, 0, 1, 11);
        step(0, 0, 8'h00, 0, 1, 3);

        // Asynchronous reset in the middle of RUN
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("tp_async_wv", 32'(win_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 0, 8'h00, 0, 0, 0);
        step(0, 1, 8'h69, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
